value_router: RTL and testbench

//  Compare/route datapath for one QuickQ sorted-array priority-queue node. The array is held in BRAM,

---
 rtl/value_router.sv | 217 +++++++++++++++++++++
 tb/tb_value_router.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/value_router.sv
// ---------------------------------------------------------------------------
// value_router
//
// Compare/route datapath for one QuickQ sorted-array priority-queue node.
// The array lives in BRAM, sorted ascending from address 0, and an all-ones
// word marks an empty slot.
//
// Insert walk: each BRAM word (bram_out) is compared with the value carried
// in the node register (reg_out). The smaller one is written back to BRAM and
// the larger one is carried onward to the next slot.
//
// Remove walk: entries shift down one slot. Each word read is handed to the
// previous node and written back until the first empty slot ends the line.
//
// The block also keeps the element count, the full/empty flags and the
// address of the last occupied slot.
//
// Ports
//   clk            in   1       rising-edge clock
//   rst            in   1       synchronous reset, active-high
//   bram_out       in   DATA_W  word read from BRAM at the current address
//   reg_out        in   DATA_W  value currently carried in the node register
//   mode           in   3       operation select (see the MODE_* constants)
//   array_size     in   CNT_W   capacity of the array (number of slots)
//   array_cnt_in   in   CNT_W   current element count / index from controller
//   bram_insert    out  DATA_W  word to write back to BRAM
//   to_register    out  DATA_W  value to load into the node register
//   last_addr      out  CNT_W   address of the last occupied slot
//   data_lt_o      out  DATA_W  value for the previous node (min on insert,
//                               shifted word on remove)
//   array_cnt_out  out  CNT_W   updated element count
//   result         out  1       insert: reg_out was placed;
//                               remove: a valid word was shifted
//   full           out  1       array_cnt_out >= array_size
//   empty          out  1       array_cnt_out == 0
//   done           out  1       one-cycle pulse when a walk finishes
//
// Every output is registered: inputs sampled on a rising edge show their
// effect just after that edge. The block has no handshake; the controller
// presents one operation per cycle through mode and consumes the results on
// the following cycle.
// ---------------------------------------------------------------------------
module value_router #(
    parameter int                DATA_W    = 32,
    parameter int                CNT_W     = 32,
    parameter logic [DATA_W-1:0] EMPTY_VAL = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bram_out,
    input  logic [DATA_W-1:0] reg_out,
    input  logic [2:0]        mode,
    input  logic [CNT_W-1:0]  array_size,
    input  logic [CNT_W-1:0]  array_cnt_in,
    output logic [DATA_W-1:0] bram_insert,
    output logic [DATA_W-1:0] to_register,
    output logic [CNT_W-1:0]  last_addr,
    output logic [DATA_W-1:0] data_lt_o,
    output logic [CNT_W-1:0]  array_cnt_out,
    output logic              result,
    output logic              full,
    output logic              empty,
    output logic              done
);

    // -----------------------------------------------------------------------
    // Operation codes
    // -----------------------------------------------------------------------
    localparam logic [2:0] MODE_INSERT_CMP = 3'b000;
    localparam logic [2:0] MODE_INSERT_CNT = 3'b001;
    localparam logic [2:0] MODE_LAST_IDX   = 3'b010;
    localparam logic [2:0] MODE_REMOVE_CMP = 3'b011;
    localparam logic [2:0] MODE_REMOVE_CNT = 3'b100;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -----------------------------------------------------------------------
    // Compare stage (unsigned)
    // -----------------------------------------------------------------------
    logic              slot_empty;
    logic              reg_lt_bram;
    logic [DATA_W-1:0] min_val;

    assign slot_empty  = (bram_out == EMPTY_VAL);
    assign reg_lt_bram = (reg_out < bram_out);
    assign min_val     = reg_lt_bram ? reg_out : bram_out;

    // -----------------------------------------------------------------------
    // Count stage
    // -----------------------------------------------------------------------
    logic             can_grow;
    logic             can_shrink;
    logic [CNT_W-1:0] cnt_grown;
    logic [CNT_W-1:0] cnt_shrunk;

    // can_grow guarantees array_cnt_in < array_size, so the increment can
    // never wrap; the decrement is only used when the count is non-zero.
    assign can_grow   = (array_cnt_in < array_size);
    assign can_shrink = (array_cnt_in != CNT_ZERO);
    assign cnt_grown  = can_grow   ? (array_cnt_in + CNT_ONE) : array_cnt_in;
    assign cnt_shrunk = can_shrink ? (array_cnt_in - CNT_ONE) : CNT_ZERO;

    // Index of the last occupied slot for a given element count; an empty
    // array reports address 0 rather than wrapping to all ones.
    function automatic logic [CNT_W-1:0] last_of(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_ZERO) ? CNT_ZERO : (cnt - CNT_ONE);
    endfunction

    // -----------------------------------------------------------------------
    // Next-value selection. Anything a mode does not mention holds its value,
    // while result and done default to 0 so they pulse for a single cycle.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] bram_insert_nxt;
    logic [DATA_W-1:0] to_register_nxt;
    logic [DATA_W-1:0] data_lt_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  last_addr_nxt;
    logic              result_nxt;
    logic              done_nxt;

    always_comb begin
        bram_insert_nxt = bram_insert;
        to_register_nxt = to_register;
        data_lt_nxt     = data_lt_o;
        cnt_nxt         = array_cnt_out;
        last_addr_nxt   = last_addr;
        result_nxt      = 1'b0;
        done_nxt        = 1'b0;

        case (mode)
            MODE_INSERT_CMP: begin
                cnt_nxt     = array_cnt_in;
                data_lt_nxt = min_val;
                if (slot_empty) begin
                    // Carried value lands in the first free slot: walk ends.
                    bram_insert_nxt = reg_out;
                    to_register_nxt = EMPTY_VAL;
                    result_nxt      = 1'b1;
                    done_nxt        = 1'b1;
                end else if (reg_lt_bram) begin
                    // Carried value displaces the stored word, which moves on.
                    bram_insert_nxt = reg_out;
                    to_register_nxt = bram_out;
                    result_nxt      = 1'b1;
                end else begin
                    // Stored word stays; keep carrying the same value.
                    bram_insert_nxt = bram_out;
                    to_register_nxt = reg_out;
                end
            end

            MODE_INSERT_CNT: begin
                cnt_nxt       = cnt_grown;
                last_addr_nxt = last_of(cnt_grown);
            end

            MODE_LAST_IDX: begin
                cnt_nxt       = array_cnt_in;
                last_addr_nxt = array_cnt_in;
            end

            MODE_REMOVE_CMP: begin
                cnt_nxt         = array_cnt_in;
                to_register_nxt = reg_out;
                if (slot_empty) begin
                    // First empty slot: nothing more to shift down.
                    bram_insert_nxt = EMPTY_VAL;
                    data_lt_nxt     = EMPTY_VAL;
                    done_nxt        = 1'b1;
                end else begin
                    bram_insert_nxt = bram_out;
                    data_lt_nxt     = bram_out;
                    result_nxt      = 1'b1;
                end
            end

            MODE_REMOVE_CNT: begin
                cnt_nxt       = cnt_shrunk;
                last_addr_nxt = last_of(cnt_shrunk);
            end

            default: begin
                // Idle codes: hold everything, pulses stay low.
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output registers. Flags follow the count being registered this cycle,
    // so they always agree with array_cnt_out.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bram_insert   <= EMPTY_VAL;
            to_register   <= EMPTY_VAL;
            data_lt_o     <= EMPTY_VAL;
            array_cnt_out <= CNT_ZERO;
            last_addr     <= CNT_ZERO;
            result        <= 1'b0;
            full          <= 1'b0;
            empty         <= 1'b1;
            done          <= 1'b0;
        end else begin
            bram_insert   <= bram_insert_nxt;
            to_register   <= to_register_nxt;
            data_lt_o     <= data_lt_nxt;
            array_cnt_out <= cnt_nxt;
            last_addr     <= last_addr_nxt;
            result        <= result_nxt;
            full          <= (cnt_nxt >= array_size);
            empty         <= (cnt_nxt == CNT_ZERO);
            done          <= done_nxt;
        end
    end

endmodule

// File: tb/tb_value_router.sv
// ---------------------------------------------------------------------------
// tb_value_router
//
// Bench for value_router: a hand-derived vector table covering the documented
// scenarios, then a randomized run compared against a behavioural model of
// the node's rules.
// ---------------------------------------------------------------------------
module tb_value_router;

    localparam logic [31:0] E = 32'hFFFF_FFFF;

    // -------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bram_out, reg_out, array_size, array_cnt_in;
    logic [2:0]  mode;
    logic [31:0] bram_insert, to_register, last_addr, data_lt_o, array_cnt_out;
    logic        result, full, empty, done;

    always #5 clk = ~clk;

    value_router dut (
        .clk          (clk),
        .rst          (rst),
        .bram_out     (bram_out),
        .reg_out      (reg_out),
        .mode         (mode),
        .array_size   (array_size),
        .array_cnt_in (array_cnt_in),
        .bram_insert  (bram_insert),
        .to_register  (to_register),
        .last_addr    (last_addr),
        .data_lt_o    (data_lt_o),
        .array_cnt_out(array_cnt_out),
        .result       (result),
        .full         (full),
        .empty        (empty),
        .done         (done)
    );

    // -------------------------------------------------------------------
    // Records
    // -------------------------------------------------------------------
    typedef struct {
        logic [31:0] bi, tr, dl, cnt, la;
        logic        res, fl, em, dn;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [2:0]  mode;
        logic [31:0] bram, rg, size, cnt;
        outs_t       exp;
    } vec_t;

    int    total_cnt = 0;
    int    pass_cnt  = 0;
    outs_t model;

    function automatic outs_t mk_out(logic [31:0] bi, logic [31:0] tr,
                                     logic [31:0] dl, logic [31:0] cnt,
                                     logic [31:0] la, logic res, logic fl,
                                     logic em, logic dn);
        outs_t o;
        o.bi = bi; o.tr = tr; o.dl = dl; o.cnt = cnt; o.la = la;
        o.res = res; o.fl = fl; o.em = em; o.dn = dn;
        return o;
    endfunction

    function automatic vec_t mk_vec(logic r, logic [2:0] m, logic [31:0] b,
                                    logic [31:0] g, logic [31:0] s,
                                    logic [31:0] c, outs_t e);
        vec_t v;
        v.rst = r; v.mode = m; v.bram = b; v.rg = g; v.size = s; v.cnt = c;
        v.exp = e;
        return v;
    endfunction

    // -------------------------------------------------------------------
    // Behavioural reference: the node's rules with plain 64-bit arithmetic
    // -------------------------------------------------------------------
    function automatic outs_t ref_step(outs_t s, logic r, logic [2:0] m,
                                       logic [31:0] b, logic [31:0] g,
                                       logic [31:0] sz, logic [31:0] c);
        outs_t  n;
        longint cnt_v, size_v, new_cnt;
        n = s;
        n.res = 1'b0;
        n.dn  = 1'b0;
        cnt_v  = longint'({32'd0, c});
        size_v = longint'({32'd0, sz});
        if (r) return mk_out(E, E, E, 0, 0, 0, 0, 1, 0);
        new_cnt = longint'({32'd0, s.cnt});
        if (m == 3'd0) begin
            new_cnt = cnt_v;
            n.dl = (longint'({32'd0, b}) < longint'({32'd0, g})) ? b : g;
            if (b == E) begin
                n.bi = g; n.tr = E; n.res = 1; n.dn = 1;
            end else if (longint'({32'd0, g}) < longint'({32'd0, b})) begin
                n.bi = g; n.tr = b; n.res = 1;
            end else begin
                n.bi = b; n.tr = g;
            end
        end else if (m == 3'd1) begin
            new_cnt = (cnt_v < size_v) ? cnt_v + 1 : cnt_v;
            n.la = (new_cnt == 0) ? 32'd0 : 32'(new_cnt - 1);
        end else if (m == 3'd2) begin
            new_cnt = cnt_v;
            n.la = c;
        end else if (m == 3'd3) begin
            new_cnt = cnt_v;
            n.tr = g;
            n.bi = b; n.dl = b;
            if (b == E) n.dn = 1; else n.res = 1;
        end else if (m == 3'd4) begin
            new_cnt = (cnt_v > 0) ? cnt_v - 1 : 0;
            n.la = (new_cnt == 0) ? 32'd0 : 32'(new_cnt - 1);
        end
        n.cnt = 32'(new_cnt);
        n.fl  = (new_cnt >= size_v);
        n.em  = (new_cnt == 0);
        return n;
    endfunction

    // -------------------------------------------------------------------
    // Driver and scoreboard
    // -------------------------------------------------------------------
    task automatic drive(logic r, logic [2:0] m, logic [31:0] b,
                         logic [31:0] g, logic [31:0] s, logic [31:0] c);
        @(negedge clk);
        rst = r; mode = m; bram_out = b; reg_out = g;
        array_size = s; array_cnt_in = c;
        model = ref_step(model, r, m, b, g, s, c);
        @(posedge clk);
        #1;
    endtask

    task automatic check_field(string tag, string name, logic [31:0] act,
                               logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s.%s: got %h expected %h", tag, name, act, exp);
    endtask

    task automatic check_outs(string tag, outs_t e);
        check_field(tag, "bram_insert",   bram_insert,   e.bi);
        check_field(tag, "to_register",   to_register,   e.tr);
        check_field(tag, "data_lt_o",     data_lt_o,     e.dl);
        check_field(tag, "array_cnt_out", array_cnt_out, e.cnt);
        check_field(tag, "last_addr",     last_addr,     e.la);
        check_field(tag, "result",        32'(result),   32'(e.res));
        check_field(tag, "full",          32'(full),     32'(e.fl));
        check_field(tag, "empty",         32'(empty),    32'(e.em));
        check_field(tag, "done",          32'(done),     32'(e.dn));
    endtask

    // -------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------
    vec_t vecs[$];

    initial begin
        rst = 1'b1; mode = 3'b111; bram_out = '0; reg_out = '0;
        array_size = 32'd5; array_cnt_in = '0;
        model = mk_out(E, E, E, 0, 0, 0, 0, 1, 0);

        // Hand-derived vectors; size 5 unless stated.
        //                 rst mode bram          reg    size cnt
        vecs.push_back(mk_vec(1, 3'd0, 32'd10,     32'd20, 5, 3, mk_out(E, E, E, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mk_vec(0, 3'd0, E,          32'd2,  5, 0, mk_out(2, E, 2, 0, 0, 1, 0, 1, 1)));
        vecs.push_back(mk_vec(0, 3'd1, 32'd0,      32'd0,  5, 0, mk_out(2, E, 2, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk_vec(0, 3'd0, 32'd2,      32'd1,  5, 1, mk_out(1, 2, 1, 1, 0, 1, 0, 0, 0)));
        vecs.push_back(mk_vec(0, 3'd0, 32'd2,      32'd3,  5, 1, mk_out(2, 3, 2, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk_vec(0, 3'd1, 32'd0,      32'd0,  5, 4, mk_out(2, 3, 2, 5, 4, 0, 1, 0, 0)));
        vecs.push_back(mk_vec(0, 3'd1, 32'd0,      32'd0,  5, 5, mk_out(2, 3, 2, 5, 4, 0, 1, 0, 0)));
        vecs.push_back(mk_vec(0, 3'd2, 32'd0,      32'd0,  5, 3, mk_out(2, 3, 2, 3, 3, 0, 0, 0, 0)));
        vecs.push_back(mk_vec(0, 3'd3, 32'h39B034AC, 32'd7, 5, 2, mk_out(32'h39B034AC, 7, 32'h39B034AC, 2, 3, 1, 0, 0, 0)));
        vecs.push_back(mk_vec(0, 3'd3, E,          32'd7,  5, 2, mk_out(E, 7, E, 2, 3, 0, 0, 0, 1)));
        vecs.push_back(mk_vec(0, 3'd4, 32'd0,      32'd0,  5, 2, mk_out(E, 7, E, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk_vec(0, 3'd5, 32'd0,      32'd0,  5, 4, mk_out(E, 7, E, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk_vec(0, 3'd4, 32'd0,      32'd0,  5, 0, mk_out(E, 7, E, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mk_vec(0, 3'd1, 32'd0,      32'd0,  0, 0, mk_out(E, 7, E, 0, 0, 0, 1, 1, 0)));
        vecs.push_back(mk_vec(0, 3'd0, 32'd5,      32'd5,  5, 0, mk_out(5, 5, 5, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mk_vec(0, 3'd0, 32'hFFFFFFFE, E,    5, 2, mk_out(32'hFFFFFFFE, E, 32'hFFFFFFFE, 2, 0, 0, 0, 0, 0)));
        vecs.push_back(mk_vec(1, 3'd0, 32'd10,     32'd20, 5, 3, mk_out(E, E, E, 0, 0, 0, 0, 1, 0)));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].mode, vecs[i].bram, vecs[i].rg,
                  vecs[i].size, vecs[i].cnt);
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset in the middle of an insert walk, then a single-cycle pulse
        // check: done must fall when the next mode is idle.
        drive(0, 3'd1, 0, 0, 5, 2);
        drive(0, 3'd0, 32'd9, 32'd4, 5, 3);
        check_outs("walk_mid", model);
        drive(1, 3'd0, E, 32'd4, 5, 3);
        check_outs("walk_rst", model);
        drive(0, 3'd0, E, 32'd8, 5, 0);
        check_outs("pulse_on", model);
        drive(0, 3'd7, E, 32'd8, 5, 0);
        check_outs("pulse_off", model);

        // Randomized run against the reference model
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic [2:0]  m;
            logic [31:0] b, g, s, c;
            r = ($urandom_range(0, 39) == 0);
            m = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       b = E;
                1:       b = 32'($urandom_range(0, 15));
                2:       b = E - 32'($urandom_range(0, 2));
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0:       g = 32'($urandom_range(0, 15));
                1:       g = b;
                default: g = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                s = E;
                c = E - 32'($urandom_range(0, 1));
            end else begin
                s = 32'($urandom_range(0, 8));
                c = 32'($urandom_range(0, 10));
            end
            drive(r, m, b, g, s, c);
            check_outs($sformatf("rnd%0d", i), model);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
